iterative_fixed_point_unit: RTL and testbench

Parametrised, multi-cycle signed fixed-point arithmetic unit: ADD, SUB, MUL and SQRT on WIDTH-bit Q(WIDTH-FBITS).FBITS operands. It is the successor to the combinational single-width FPU and sits beside the integer ALU in the execute stage. MUL and SQRT run as iterative datapaths behind a start/busy/ready handshake, and every result reports an overflow/invalid flag.

---
 rtl/iterative_fixed_point_unit_pkg.sv | 30 +++
 rtl/iterative_fixed_point_unit_if.sv | 36 +++
 rtl/iterative_fixed_point_unit_seq_shift_add_multiplier.sv | 53 +++++
 rtl/iterative_fixed_point_unit.sv | 202 ++++++++++++++++++++
 tb/tb_iterative_fixed_point_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/iterative_fixed_point_unit_pkg.sv
// fpu_pkg: shared types and helpers for iterative_fixed_point_unit.
//   fpu_op_t     - operation encodings (ADD/SUB/MUL/SQRT)
//   fpu_state_t  - control FSM states, also exported on the debug port
//   mul_latency  - edges from accept to ready for MUL
//   sqrt_latency - edges from accept to ready for a non-negative SQRT
package fpu_pkg;

    typedef enum logic [1:0] {
        FPU_ADD  = 2'b00,
        FPU_SUB  = 2'b01,
        FPU_MUL  = 2'b10,
        FPU_SQRT = 2'b11
    } fpu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_SQRT = 2'b10,
        ST_DONE = 2'b11
    } fpu_state_t;

    function automatic int mul_latency(input int width);
        return width + 1;
    endfunction

    function automatic int sqrt_latency(input int width, input int fbits);
        return (width + fbits) / 2 + 1;
    endfunction

endpackage

// File: rtl/iterative_fixed_point_unit_if.sv
// iterative_fixed_point_unit_if: request/response bundle of the fixed-point unit.
//   start, operation, operand_1, operand_2 : requester -> unit
//   result, ready, busy, overflow          : unit -> requester
//   state                                  : unit -> observer (FSM debug view)
//
// Handshake: the unit accepts a request on any rising edge where start=1 and
// busy=0 (FSM in IDLE or DONE); start while busy=1 is dropped, not queued.
// ready is a one-cycle pulse marking result/overflow valid; those two hold
// their value until the next accepted operation completes.
interface iterative_fixed_point_unit_if
    import fpu_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [1:0]       operation;
    logic [WIDTH-1:0] operand_1;
    logic [WIDTH-1:0] operand_2;
    logic [WIDTH-1:0] result;
    logic             ready;
    logic             busy;
    logic             overflow;
    fpu_state_t       state;

    modport master (
        output start, operation, operand_1, operand_2,
        input  result, ready, busy, overflow, state
    );

    modport slave (
        input  start, operation, operand_1, operand_2,
        output result, ready, busy, overflow, state
    );

endinterface

// File: rtl/iterative_fixed_point_unit_seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: unsigned WIDTH x WIDTH radix-2 shift-add multiplier.
//   clk, reset    - clock, asynchronous active-low reset
//   load          - capture operands; bit 0 of multiplier is folded in here
//   multiplicand  - unsigned operand A
//   multiplier    - unsigned operand B, consumed one bit per cycle
//   product       - 2*WIDTH-bit accumulator (final once done=1)
//   done          - no bits left to consume
// The load edge handles bit 0 so the remaining WIDTH-1 bits finish one edge
// before the parent needs the product, leaving it a cycle to apply the sign.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            acc_q    <= multiplier[0] ? (2*WIDTH)'(multiplicand) : '0;
            mcand_q  <= (2*WIDTH)'(multiplicand) << 1;
            mplier_q <= multiplier >> 1;
            cnt_q    <= CW'(WIDTH - 1);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
        end
    end

    assign product = acc_q;
    assign done    = (cnt_q == '0);

endmodule

// File: rtl/iterative_fixed_point_unit.sv
// iterative_fixed_point_unit: multi-cycle signed Q(WIDTH-FBITS).FBITS unit.
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - iterative_fixed_point_unit_if.slave (start/operation/operands in,
//           result/ready/busy/overflow/state out)
// ADD/SUB finish on the accepting edge, MUL iterates WIDTH cycles through
// seq_shift_add_multiplier, SQRT runs a restoring two-bits-per-cycle root.
// Build option FPU_SATURATE_EN: clamp ADD/SUB/MUL results on overflow to the
// most-positive / most-negative value by the true sign; otherwise wrap.
module iterative_fixed_point_unit
    import fpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FBITS = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    iterative_fixed_point_unit_if.slave bus
);

    localparam int RW   = WIDTH + FBITS;   // radicand width
    localparam int NSQ  = RW / 2;          // root bits = sqrt iterations
    localparam int RMW  = NSQ + 3;         // partial remainder width
    localparam int CW   = $clog2(WIDTH + 1);

    // Signed magnitude limit of the un-scaled product: floor(P / 2^FBITS)
    // fits in WIDTH bits exactly when -LIM <= P < LIM, LIM = 2^(WIDTH+FBITS-1).
    localparam logic [2*WIDTH-1:0] MUL_LIM =
        {{(WIDTH-FBITS){1'b0}}, 1'b1, {(WIDTH+FBITS-1){1'b0}}};

`ifdef FPU_SATURATE_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    fpu_state_t       state_q, state_n, accept_target;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic [RW-1:0]    rad_q;
    logic [RMW-1:0]   rem_q;
    logic [NSQ-1:0]   root_q;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q, ready_q, busy_q;

    fpu_op_t          op_in;
    logic             accept, op1_neg, op2_neg;
    logic [WIDTH-1:0] mag_1, mag_2;
    logic [WIDTH-1:0] sum, diff;
    logic             add_ovf, sub_ovf;

    logic [2*WIDTH-1:0] product, acc_signed;
    logic               mul_done, mul_ovf;
    logic [WIDTH-1:0]   mag_trunc, mul_res;

    logic [RMW-1:0]   rem_shift, rem_trial, rem_n;
    logic             sq_ge;
    logic [NSQ-1:0]   root_n;

    logic [WIDTH-1:0] res_n;
    logic             ovf_n;

    assign op_in   = fpu_op_t'(bus.operation);
    assign accept  = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign op1_neg = bus.operand_1[WIDTH-1];
    assign op2_neg = bus.operand_2[WIDTH-1];
    assign mag_1   = op1_neg ? -bus.operand_1 : bus.operand_1;
    assign mag_2   = op2_neg ? -bus.operand_2 : bus.operand_2;

    assign sum     = bus.operand_1 + bus.operand_2;
    assign diff    = bus.operand_1 - bus.operand_2;
    assign add_ovf = (op1_neg == op2_neg) && (sum[WIDTH-1] != op1_neg);
    assign sub_ovf = (op1_neg != op2_neg) && (diff[WIDTH-1] != op1_neg);

    seq_shift_add_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .reset        (reset),
        .load         (accept && op_in == FPU_MUL),
        .multiplicand (mag_1),
        .multiplier   (mag_2),
        .product      (product),
        .done         (mul_done)
    );

    // Truncate the magnitude before re-applying the sign so the fractional
    // drop rounds toward zero for negative products too.
    assign acc_signed = neg_q ? -product : product;
    assign mag_trunc  = product[WIDTH+FBITS-1:FBITS];
    assign mul_res    = neg_q ? -mag_trunc : mag_trunc;
    assign mul_ovf    = ($signed(acc_signed) >= $signed(MUL_LIM)) ||
                        ($signed(acc_signed) < -$signed(MUL_LIM));

    // One restoring root step: bring down two radicand bits, try 4*root+1.
    assign rem_shift = (rem_q << 2) | RMW'(rad_q[RW-1 -: 2]);
    assign rem_trial = RMW'({root_q, 2'b01});
    assign sq_ge     = (rem_shift >= rem_trial);
    assign rem_n     = sq_ge ? (rem_shift - rem_trial) : rem_shift;
    assign root_n    = {root_q[NSQ-2:0], sq_ge};

    always_comb begin
        accept_target = ST_DONE;
        case (op_in)
            FPU_MUL:  accept_target = ST_MUL;
            FPU_SQRT: accept_target = op1_neg ? ST_DONE : ST_SQRT;
            default:  accept_target = ST_DONE;
        endcase

        state_n = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_n = accept_target;
            ST_MUL:  if (cnt_q == CW'(1) && mul_done) state_n = ST_DONE;
            ST_SQRT: if (cnt_q == CW'(1)) state_n = ST_DONE;
            ST_DONE: state_n = accept ? accept_target : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Result/flag candidate; only latched when the FSM enters DONE.
    always_comb begin
        res_n = result_q;
        ovf_n = 1'b0;
        if (accept) begin
            case (op_in)
                FPU_ADD: begin
                    res_n = sum;
                    ovf_n = add_ovf;
`ifdef FPU_SATURATE_EN
                    if (add_ovf) res_n = op1_neg ? MAX_NEG : MAX_POS;
`endif
                end
                FPU_SUB: begin
                    res_n = diff;
                    ovf_n = sub_ovf;
`ifdef FPU_SATURATE_EN
                    if (sub_ovf) res_n = op1_neg ? MAX_NEG : MAX_POS;
`endif
                end
                FPU_SQRT: begin
                    // Only reaches DONE from here for a negative radicand.
                    res_n = '0;
                    ovf_n = 1'b1;
                end
                default: begin
                    res_n = result_q;
                    ovf_n = 1'b0;
                end
            endcase
        end else if (state_q == ST_MUL) begin
            res_n = mul_res;
            ovf_n = mul_ovf;
`ifdef FPU_SATURATE_EN
            if (mul_ovf) res_n = neg_q ? MAX_NEG : MAX_POS;
`endif
        end else begin
            res_n = WIDTH'(root_n);
            ovf_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            ready_q <= (state_n == ST_DONE);
            busy_q  <= (state_n == ST_MUL) || (state_n == ST_SQRT);
            if (accept) begin
                neg_q  <= op1_neg ^ op2_neg;
                cnt_q  <= (op_in == FPU_MUL) ? CW'(WIDTH) : CW'(NSQ);
                rad_q  <= RW'(bus.operand_1) << FBITS;
                rem_q  <= '0;
                root_q <= '0;
            end else if (busy_q) begin
                cnt_q <= cnt_q - CW'(1);
                if (state_q == ST_SQRT) begin
                    rad_q  <= rad_q << 2;
                    rem_q  <= rem_n;
                    root_q <= root_n;
                end
            end
            if (state_n == ST_DONE) begin
                result_q <= res_n;
                ovf_q    <= ovf_n;
            end
        end
    end

    assign bus.result   = result_q;
    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_iterative_fixed_point_unit.sv
// Testbench for iterative_fixed_point_unit (WIDTH=32, FBITS=10).
module tb_iterative_fixed_point_unit;
    import fpu_pkg::*;

    localparam int WB      = 32;
    localparam int FB      = 10;
    localparam int TIMEOUT = 200;
    localparam longint MAX_V = (longint'(1) <<< (WB - 1)) - 1;
    localparam longint MIN_V = -(longint'(1) <<< (WB - 1));

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [WB-1:0] exp_q[$];

    iterative_fixed_point_unit_if #(.WIDTH(WB)) bus ();

    iterative_fixed_point_unit #(.WIDTH(WB), .FBITS(FB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    function automatic void model(input logic [1:0] op, input logic [WB-1:0] a,
                                  input logic [WB-1:0] b, output logic [WB-1:0] r,
                                  output logic o, output int lat);
        longint sa, sb, s, p, fl, q, rad, x;
        real    rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; o = 1'b0; lat = 1;
        case (op)
            2'b00, 2'b01: begin
                s = (op == 2'b00) ? sa + sb : sa - sb;
                o = (s > MAX_V) || (s < MIN_V);
                r = s[WB-1:0];
`ifdef FPU_SATURATE_EN
                if (o) r = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
            end
            2'b10: begin
                p  = sa * sb;
                fl = p >>> FB;
                o  = (fl > MAX_V) || (fl < MIN_V);
                q  = p / (longint'(1) <<< FB);
                r  = q[WB-1:0];
`ifdef FPU_SATURATE_EN
                if (o) r = (p < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
                lat = WB + 1;
            end
            default: begin
                if (sa < 0) begin
                    r = '0; o = 1'b1; lat = 1;
                end else begin
                    rad = sa <<< FB;
                    rr  = $sqrt(real'(rad));
                    x   = longint'($floor(rr));
                    while (x * x > rad) x = x - 1;
                    while ((x + 1) * (x + 1) <= rad) x = x + 1;
                    r   = x[WB-1:0];
                    lat = (WB + FB) / 2 + 1;
                end
            end
        endcase
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [WB-1:0] rnd_operand();
        logic [WB-1:0] v;
        case ($urandom_range(0, 2))
            0:       v = $urandom;
            1:       v = WB'($urandom_range(0, 32'h0000_FFFF));
            default: v = -WB'($urandom_range(0, 32'h0000_FFFF));
        endcase
        return v;
    endfunction

    // ---------------- driver ----------------
    // Issues one request, optionally pulses a stray ADD start at iteration
    // 'intrude', waits for ready and checks latency, result, flag and busy.
    task automatic do_op(input logic [1:0] op, input logic [WB-1:0] a, input logic [WB-1:0] b,
                         input string tag, input int intrude, output logic [WB-1:0] got);
        logic [WB-1:0] e_res;
        logic          e_ovf;
        int            e_lat, lat, busy_cycles;
        model(op, a, b, e_res, e_ovf, e_lat);
        exp_q.push_back(e_res);
        @(negedge clk);
        bus.start = 1'b1; bus.operation = op; bus.operand_1 = a; bus.operand_2 = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1; busy_cycles = 0;
        while (bus.ready !== 1'b1 && lat < TIMEOUT) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (lat == intrude) begin
                bus.start = 1'b1; bus.operation = FPU_ADD;
                bus.operand_1 = $urandom; bus.operand_2 = $urandom;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            lat++;
        end
        got = bus.result;
        chk({tag, "_lat"}, lat, e_lat);
        chk({tag, "_res"}, bus.result, exp_q.pop_front());
        chk({tag, "_ovf"}, bus.overflow, e_ovf);
        chk({tag, "_busy_cycles"}, busy_cycles, e_lat - 1);
        chk({tag, "_busy_at_ready"}, bus.busy, 0);
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        chk({tag, "_ready_pulse"}, bus.ready, 0);
        chk({tag, "_idle"}, WB'(bus.state), WB'(ST_IDLE));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [WB-1:0] got, a, b;
        logic [1:0]    op;
        int            gap, rdy_cnt;

        reset = 1'b0;
        bus.start = 1'b0; bus.operation = 2'b00; bus.operand_1 = '0; bus.operand_2 = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_result", bus.result, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_state", WB'(bus.state), WB'(ST_IDLE));
        @(negedge clk); reset = 1'b1;

        do_op(FPU_ADD, 32'h0000_0600, 32'h0000_0400, "add", 0, got);
        chk("plan_add", got, 32'h0000_0A00);
        idle_check("add");

        do_op(FPU_MUL, 32'h0000_0600, 32'h0000_0800, "mul_pos", 0, got);
        chk("plan_mul_pos", got, 32'h0000_0C00);
        idle_check("mul_pos");

        do_op(FPU_MUL, 32'hFFFF_FA00, 32'h0000_0800, "mul_neg", 0, got);
        chk("plan_mul_neg", got, 32'hFFFF_F400);

        do_op(FPU_SQRT, 32'h0000_1000, 32'h0, "sqrt_4", 0, got);
        chk("plan_sqrt_4", got, 32'h0000_0800);

        do_op(FPU_SQRT, 32'h0000_0800, 32'h0, "sqrt_2", 0, got);
        chk("plan_sqrt_2", got, 32'h0000_05A8);

        do_op(FPU_SQRT, 32'hFFFF_FC00, 32'h0, "sqrt_neg", 0, got);
        chk("plan_sqrt_neg", got, 32'h0000_0000);
        idle_check("sqrt_neg");

        do_op(FPU_SUB, 32'h8000_0000, 32'h0000_0001, "sub_ovf", 0, got);

        do_op(FPU_SQRT, 32'h0000_1000, 32'h0, "sqrt_intrude", 5, got);
        chk("plan_sqrt_intrude", got, 32'h0000_0800);
        do_op(FPU_ADD, 32'h0000_0100, 32'h0000_0200, "add_in_done", 0, got);
        chk("plan_add_in_done", got, 32'h0000_0300);

        do_op(FPU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, "add_ovf", 0, got);
`ifdef FPU_SATURATE_EN
        chk("plan_add_ovf", got, 32'h7FFF_FFFF);
`else
        chk("plan_add_ovf", got, 32'h8000_0000);
`endif
        idle_check("add_ovf");

        // Reset in the middle of a MUL.
        @(negedge clk);
        bus.start = 1'b1; bus.operation = FPU_MUL;
        bus.operand_1 = 32'h0000_0600; bus.operand_2 = 32'h0000_0800;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_result", bus.result, 0);
        chk("mid_rst_ready", bus.ready, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_overflow", bus.overflow, 0);
        chk("mid_rst_state", WB'(bus.state), WB'(ST_IDLE));
        @(negedge clk); reset = 1'b1;
        rdy_cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.ready === 1'b1) rdy_cnt++;
        end
        chk("no_spurious_ready", rdy_cnt, 0);
        do_op(FPU_MUL, 32'h0000_0C00, 32'hFFFF_F800, "mul_after_rst", 0, got);
        chk("plan_mul_after_rst", got, 32'hFFFF_E800);

        // Randomized traffic with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = rnd_operand();
            b  = rnd_operand();
            do_op(op, a, b, "rand", 0, got);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                idle_check("rand");
                repeat (gap - 1) @(posedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
